aes128_round_ctrl: RTL and testbench
====================================

# aes128_round_ctrl

Iterative AES-128 encryption sequencer. It drives the shared one-round datapath (add-round-key, sub-bytes, shift-rows, mix-columns, key-expansion step) through the initial key addition and rounds 1–10. The datapath follows the team's start/ready stage convention: the stage reports `ready` some cycles after `start`, and output data is combinational. The controller sits between the AXI/XDMA register front-end and the datapath, and it owns the round counter, the round constant, the mux selects and the state/key register write enables.

## Interface
- `TIMEOUT_CYC`, default 16: maximum number of cycles spent waiting for `stage_ready_i` before aborting. Range 1–255.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  one-cycle request to encrypt the block already presented to the datapath. Accepted only in IDLE or DONE.
- `stage_ready_i`  in  1  datapath completion for the current round. Ignored outside WAIT.
- `busy_o`  out  1  high from acceptance until DONE or ERR is reached.
- `stage_start_o`  out  1  one-cycle pulse launching the current round in the datapath.
- `round_o`  out  4  current round, 0–10.
- `rcon_o`  out  8  round constant for the key-expansion step of `round_o`.
- `sel_init_o`  out  1  round 0: datapath performs add-round-key only, using the input block and cipher key.
- `bypass_mix_o`  out  1  round 10: mix-columns is skipped.
- `state_we_o`  out  1  load the datapath result into the state register.
- `key_we_o`  out  1  load the expanded round key into the key register.
- `done_o`  out  1  one-cycle pulse; the ciphertext is valid in the state register.
- `err_o`  out  1  one-cycle pulse; timeout abort.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
- **IDLE / DONE:** on `start_i`, set round to 0 and go to ISSUE.
- **ISSUE:** assert `stage_start_o`, clear the timeout counter, go to WAIT.
- **WAIT, on `stage_ready_i`:**
  - Assert `state_we_o`, plus `key_we_o` when round ≥ 1. Both are combinational, in the same cycle as ready.
  - If round < 10: increment round, go to ISSUE.
  - Else: go to DONE.
- **WAIT, timeout:** if the counter reaches `TIMEOUT_CYC` without ready, go to ERR. No write enables are asserted.
- **DONE:** `done_o` is high for the one cycle spent in DONE. The FSM returns to IDLE the next cycle unless `start_i` arrives, in which case it goes directly to ISSUE.
- **ERR:** `err_o` is high for one cycle, then the FSM goes to IDLE. Round is reset to 0.
- **Round-derived outputs:**
  - `sel_init_o` = (round == 0).
  - `bypass_mix_o` = (round == 10).
  - Both are valid in ISSUE and WAIT.
- **`rcon_o` sequence:**
  - 0x00 at round 0.
  - 0x01 at round 1.
  - Thereafter xtime of the previous value, where xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0x00), truncated to 8 bits.
  - Rounds 1–10 therefore give 01 02 04 08 10 20 40 80 1B 36.
- **Ignored inputs:**
  - `start_i` while busy (in ISSUE or WAIT): no effect, not queued.
  - `stage_ready_i` in ISSUE, IDLE, DONE or ERR: no effect.

## Timing
- **Reset values:**
  - State IDLE.
  - `round_o` = 0, `rcon_o` = 0x00, `sel_init_o` = 1.
  - All other outputs 0.
- **Registered outputs:** `stage_start_o`, `done_o`, `err_o`, `busy_o`, `round_o`, `rcon_o`.
- **Combinational outputs:** `state_we_o` and `key_we_o`, decoded from WAIT && `stage_ready_i`.
- **Cycle sequence (`start_i` sampled at edge T):**
  - `stage_start_o` for round r is high in cycle T+1+2r when each stage returns ready one cycle after start.
  - Round 10 ready arrives at T+22.
  - `done_o` is high at T+23.
- **Minimum busy time:** 22 cycles per block; the datapath may take longer per round.
- **Timeout boundary:** ready arriving in exactly the cycle where the counter equals `TIMEOUT_CYC`−1 is accepted. One cycle later, ERR is taken.
- **Reset mid-operation:** the FSM returns to IDLE immediately and no write enable glitches high.

## Structure
- **Shared package `aes128_pkg`:**
  - `AES_NR` = 10.
  - FSM state enum.
  - `RCON_INIT` = 8'h01.
  - `xtime` function, also used by the mix-columns datapath.
- **Sub-module `aes128_rcon_gen`:** the rcon register with `clear`/`step` inputs, driven by the FSM.

## Test plan
- Reset, then idle for 5 cycles → `busy_o` = 0, `round_o` = 0, `rcon_o` = 0x00, no pulses.
- Single block with ready one cycle after each start → 11 `stage_start_o` pulses, `rcon_o` per round 00,01,02,04,08,10,20,40,80,1B,36, `done_o` at T+23. With the FIPS-197 C.1 key/plaintext in a datapath model, the ciphertext is 69c4e0d86a7b0430d8cdb78070b4c55a.
- Random ready delay of 1–8 cycles, plus `start_i` pulses while busy → one `done_o`, extra starts ignored, `state_we_o` asserted exactly 11 times.
- Ready withheld in round 4 with `TIMEOUT_CYC` = 16 → `err_o` pulse 16 cycles after entering WAIT, then IDLE with `round_o` = 0. A later start completes normally.
- `start_i` in the DONE cycle → the next block's round 0 `stage_start_o` is issued the following cycle, with no IDLE gap.
- `rst_n` asserted during WAIT of round 6 → all outputs at reset values asynchronously. A fresh start runs all 11 rounds.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: round count, controller state encoding,
// first round constant and the GF(2^8) doubling used by rcon and mix-columns.
package aes128_pkg;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } ctrl_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_rcon_gen.sv
// Round-constant register: cleared to 0x00 for round 0, each step moves
// it to the constant of the next round.
module aes128_rcon_gen
    import aes128_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       step,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_d;
    logic [7:0] rcon_q;

    // Round 0 carries no constant, so the first step loads 0x01 instead of doubling.
    always_comb begin
        rcon_d = rcon_q;
        if (clear) begin
            rcon_d = 8'h00;
        end else if (step) begin
            rcon_d = (rcon_q == 8'h00) ? RCON_INIT : xtime(rcon_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcon_q <= 8'h00;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 sequencer: walks the shared round datapath through the
// initial key addition and rounds 1-10, with a per-round ready timeout.
module aes128_round_ctrl
    import aes128_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       stage_ready_i,
    output logic       busy_o,
    output logic       stage_start_o,
    output logic [3:0] round_o,
    output logic [7:0] rcon_o,
    output logic       sel_init_o,
    output logic       bypass_mix_o,
    output logic       state_we_o,
    output logic       key_we_o,
    output logic       done_o,
    output logic       err_o
);

    localparam logic [3:0] LAST_ROUND = 4'(AES_NR);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);

    ctrl_state_e state_d, state_q;
    logic [3:0]  round_d, round_q;
    logic [7:0]  tmo_d, tmo_q;
    logic        stage_start_d, stage_start_q;
    logic        busy_d, busy_q;
    logic        done_d, done_q;
    logic        err_d, err_q;
    logic        rcon_clear, rcon_step;
    logic        accept_ready;

    assign accept_ready = (state_q == ST_WAIT) && stage_ready_i;

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        tmo_d      = tmo_q;
        rcon_clear = 1'b0;
        rcon_step  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d    = ST_ISSUE;
                    round_d    = 4'd0;
                    rcon_clear = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                tmo_d   = 8'd0;
            end
            ST_WAIT: begin
                if (stage_ready_i) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_ISSUE;
                        round_d   = round_q + 4'd1;
                        rcon_step = 1'b1;
                    end
                // Ready in the last counted cycle still wins; ERR follows only without it.
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = ST_ERR;
                    round_d    = 4'd0;
                    rcon_clear = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pulses and busy are registered from the next state so they line up with it.
        stage_start_d = (state_d == ST_ISSUE);
        busy_d        = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        done_d        = (state_d == ST_DONE);
        err_d         = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            round_q       <= 4'd0;
            tmo_q         <= 8'd0;
            stage_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            tmo_q         <= tmo_d;
            stage_start_q <= stage_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    aes128_rcon_gen u_rcon (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rcon_clear),
        .step   (rcon_step),
        .rcon_o (rcon_o)
    );

    assign busy_o        = busy_q;
    assign stage_start_o = stage_start_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign round_o       = round_q;
    assign sel_init_o    = (round_q == 4'd0);
    assign bypass_mix_o  = (round_q == LAST_ROUND);
    assign state_we_o    = accept_ready;
    assign key_we_o      = accept_ready && (round_q != 4'd0);

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Bench for aes128_round_ctrl: per-cycle reference model, a behavioural AES
// datapath driven by the controller, and randomized ready timing.
module tb_aes128_round_ctrl;

    localparam int TMO = 16;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [7:0] RCON_EXP [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic       clk = 1'b0;
    logic       rst_n, start_i, stage_ready_i;
    logic       busy_o, stage_start_o, sel_init_o, bypass_mix_o;
    logic       state_we_o, key_we_o, done_o, err_o;
    logic [3:0] round_o;
    logic [7:0] rcon_o;

    aes128_round_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .stage_ready_i (stage_ready_i),
        .busy_o        (busy_o),
        .stage_start_o (stage_start_o),
        .round_o       (round_o),
        .rcon_o        (rcon_o),
        .sel_init_o    (sel_init_o),
        .bypass_mix_o  (bypass_mix_o),
        .state_we_o    (state_we_o),
        .key_we_o      (key_we_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- AES reference pieces ----------------
    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sb(s[127 - 8 * i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) b[c * 4 + rr] = a[((c + rr) % 4) * 4 + rr];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = b[c * 4]; a1 = b[c * 4 + 1]; a2 = b[c * 4 + 2]; a3 = b[c * 4 + 3];
                b[c * 4]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                b[c * 4 + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                b[c * 4 + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                b[c * 4 + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = b[i];
        return r ^ rk;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] k, s;
        logic [7:0]   rc;
        k  = key;
        s  = pt ^ key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            k  = next_key(k, rc);
            s  = aes_round(s, k, r == 10);
            rc = xt(rc);
        end
        return s;
    endfunction

    // ---------------- controller reference model ----------------
    typedef enum int {P_IDLE, P_ISSUE, P_WAIT, P_DONE, P_ERR} phase_e;
    phase_e m_phase = P_IDLE;
    int     m_round = 0;
    int     m_waited = 0;
    int     cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= P_IDLE;
            m_round  <= 0;
            m_waited <= 0;
        end else begin
            case (m_phase)
                P_IDLE, P_DONE: begin
                    m_phase <= start_i ? P_ISSUE : P_IDLE;
                    if (start_i) m_round <= 0;
                end
                P_ISSUE: begin
                    m_phase  <= P_WAIT;
                    m_waited <= 0;
                end
                P_WAIT: begin
                    if (stage_ready_i) begin
                        if (m_round == 10) m_phase <= P_DONE;
                        else begin
                            m_phase <= P_ISSUE;
                            m_round <= m_round + 1;
                        end
                    end else begin
                        m_waited <= m_waited + 1;
                        if (m_waited + 1 == TMO) begin
                            m_phase <= P_ERR;
                            m_round <= 0;
                        end
                    end
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    // ---------------- compare, event log and datapath ----------------
    int           n_start = 0, n_done = 0, n_err = 0, n_swe = 0, n_kwe = 0;
    int           last_done_cyc = 0, last_err_cyc = 0;
    logic [7:0]   rcon_log [$];
    int           start_log [$];
    logic [127:0] dp_state = '0, dp_key = '0, dp_ck = '0, dp_pt = '0, last_ct = '0;

    initial forever begin
        logic exp_we;
        logic [127:0] nk;
        @(negedge clk);
        exp_we = (m_phase == P_WAIT) && stage_ready_i;
        chk("busy_o", busy_o, (m_phase == P_ISSUE) || (m_phase == P_WAIT));
        chk("stage_start_o", stage_start_o, m_phase == P_ISSUE);
        chk("done_o", done_o, m_phase == P_DONE);
        chk("err_o", err_o, m_phase == P_ERR);
        chk("round_o", round_o, m_round);
        chk("rcon_o", rcon_o, RCON_EXP[m_round]);
        chk("sel_init_o", sel_init_o, m_round == 0);
        chk("bypass_mix_o", bypass_mix_o, m_round == 10);
        chk("state_we_o", state_we_o, exp_we);
        chk("key_we_o", key_we_o, exp_we && (m_round >= 1));
        if (stage_start_o) begin
            n_start++;
            rcon_log.push_back(rcon_o);
            start_log.push_back(cyc);
        end
        if (done_o) begin
            n_done++;
            last_done_cyc = cyc;
            last_ct = dp_state;
        end
        if (err_o) begin
            n_err++;
            last_err_cyc = cyc;
        end
        if (state_we_o) n_swe++;
        if (key_we_o) n_kwe++;
        if (rst_n) begin
            if (stage_start_o && sel_init_o) dp_key = dp_ck;
            if (state_we_o) begin
                nk = next_key(dp_key, rcon_o);
                dp_state = sel_init_o ? (dp_pt ^ dp_key) : aes_round(dp_state, nk, bypass_mix_o);
                if (key_we_o) dp_key = nk;
            end
        end
    end

    // ---------------- ready responder ----------------
    int unsigned rdy_min = 1, rdy_max = 1;
    int          force_round = -1, force_delay = 0;
    logic        noise_en = 1'b0;

    initial begin
        int cnt;
        cnt = 0;
        stage_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || err_o) begin
                cnt = 0;
                stage_ready_i = 1'b0;
            end else if (stage_start_o) begin
                cnt = (int'(round_o) == force_round) ? force_delay : int'($urandom_range(rdy_max, rdy_min));
                stage_ready_i = noise_en && ($urandom_range(1, 0) == 1);
            end else if (cnt > 0) begin
                cnt--;
                stage_ready_i = (cnt == 0);
            end else begin
                stage_ready_i = (cnt == 0) && noise_en && ($urandom_range(1, 0) == 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    int t_req = 0;

    task automatic pulse_start();
        @(posedge clk);
        #1 start_i = 1'b1;
        t_req = cyc + 1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic run_to_end(input int bound, input logic inject);
        int base;
        base = n_done + n_err;
        for (int i = 0; i < bound && (n_done + n_err) == base; i++) begin
            @(posedge clk);
            #1;
            start_i = inject && (m_phase == P_ISSUE || m_phase == P_WAIT) && ($urandom_range(3, 0) == 0);
        end
        start_i = 1'b0;
        chk("end_event", (n_done + n_err) - base, 1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int b_start, b_done, b_err, b_swe, b_kwe, b_log, d_cyc;
        rst_n = 1'b1;
        start_i = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", busy_o, 0);
        chk("idle_round", round_o, 0);
        chk("idle_rcon", rcon_o, 0);
        chk("idle_sel_init", sel_init_o, 1);
        chk("idle_pulses", n_start + n_done + n_err, 0);

        // FIPS-197 C.1 block, ready one cycle after every start
        dp_ck = KEY_C1;
        dp_pt = PT_C1;
        chk("model_c1", aes_ref(KEY_C1, PT_C1), CT_C1);
        b_start = n_start; b_swe = n_swe; b_kwe = n_kwe; b_log = rcon_log.size();
        pulse_start();
        run_to_end(60, 1'b0);
        chk("c1_starts", n_start - b_start, 11);
        for (int r = 0; r < 11; r++)
            chk($sformatf("c1_rcon_r%0d", r),
                (b_log + r < rcon_log.size()) ? {120'h0, rcon_log[b_log + r]} : 128'h100, RCON_EXP[r]);
        chk("c1_first_start", (b_log < start_log.size()) ? start_log[b_log] - t_req : -1, 0);
        chk("c1_done_time", last_done_cyc - t_req, 22);
        chk("c1_state_we", n_swe - b_swe, 11);
        chk("c1_key_we", n_kwe - b_kwe, 10);
        chk("c1_ciphertext", last_ct, CT_C1);

        // random keys, ready delay 1..8, stray ready and starts while busy
        rdy_min = 1; rdy_max = 8; noise_en = 1'b1;
        for (int blk = 0; blk < 3; blk++) begin
            dp_ck = rnd128();
            dp_pt = rnd128();
            b_start = n_start; b_done = n_done; b_swe = n_swe;
            pulse_start();
            run_to_end(400, 1'b1);
            repeat (20) @(posedge clk);
            #1;
            chk("rnd_done", n_done - b_done, 1);
            chk("rnd_starts", n_start - b_start, 11);
            chk("rnd_state_we", n_swe - b_swe, 11);
            chk("rnd_ciphertext", last_ct, aes_ref(dp_ck, dp_pt));
        end

        // ready exactly at the timeout limit is still accepted
        rdy_min = 1; rdy_max = 3;
        force_round = 3; force_delay = TMO;
        b_done = n_done; b_err = n_err;
        pulse_start();
        run_to_end(200, 1'b0);
        chk("tmo_edge_done", n_done - b_done, 1);
        chk("tmo_edge_err", n_err - b_err, 0);
        chk("tmo_edge_ct", last_ct, aes_ref(dp_ck, dp_pt));

        // ready withheld in round 4
        force_round = 4; force_delay = -1;
        b_done = n_done; b_err = n_err; b_log = start_log.size();
        pulse_start();
        run_to_end(200, 1'b0);
        chk("tmo_err", n_err - b_err, 1);
        chk("tmo_done", n_done - b_done, 0);
        chk("tmo_err_time", (b_log + 4 < start_log.size()) ? last_err_cyc - start_log[b_log + 4] : -1, TMO + 1);
        chk("tmo_after_busy", busy_o, 0);
        chk("tmo_after_round", round_o, 0);
        force_round = -1;
        dp_ck = rnd128();
        dp_pt = rnd128();
        b_done = n_done;
        pulse_start();
        run_to_end(200, 1'b0);
        chk("tmo_recover_done", n_done - b_done, 1);
        chk("tmo_recover_ct", last_ct, aes_ref(dp_ck, dp_pt));

        // start in the DONE cycle chains straight into the next block
        b_done = n_done; b_start = n_start; b_log = start_log.size();
        d_cyc = -100;
        pulse_start();
        for (int i = 0; i < 200 && m_phase != P_DONE; i++) begin
            @(posedge clk);
            #1;
        end
        if (m_phase == P_DONE) begin
            start_i = 1'b1;
            d_cyc = cyc;
        end
        @(posedge clk);
        #1 start_i = 1'b0;
        run_to_end(200, 1'b0);
        chk("chain_done", n_done - b_done, 2);
        chk("chain_starts", n_start - b_start, 22);
        chk("chain_no_gap", (b_log + 11 < start_log.size()) ? start_log[b_log + 11] - d_cyc : -1, 1);
        chk("chain_ct", last_ct, aes_ref(dp_ck, dp_pt));

        // asynchronous reset while waiting in round 6
        pulse_start();
        for (int i = 0; i < 200 && !(m_phase == P_WAIT && m_round == 6); i++) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_stage_start", stage_start_o, 0);
        chk("rst_round", round_o, 0);
        chk("rst_rcon", rcon_o, 0);
        chk("rst_sel_init", sel_init_o, 1);
        chk("rst_bypass", bypass_mix_o, 0);
        chk("rst_state_we", state_we_o, 0);
        chk("rst_key_we", key_we_o, 0);
        chk("rst_done_err", {done_o, err_o}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        dp_ck = rnd128();
        dp_pt = rnd128();
        b_done = n_done; b_start = n_start;
        pulse_start();
        run_to_end(400, 1'b0);
        chk("post_rst_starts", n_start - b_start, 11);
        chk("post_rst_done", n_done - b_done, 1);
        chk("post_rst_ct", last_ct, aes_ref(dp_ck, dp_pt));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_fail);
        $fatal(1, "bench time limit reached");
    end

endmodule
